// File: rtl/mips_instr_encoder_if.sv
// Handshake and control bundle between an instruction source and mips_instr_encoder.
interface mips_instr_encoder_if #(
    parameter int unsigned AW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    in_opcode;
    logic [3:0]    in_aluop;
    logic [4:0]    in_rs;
    logic [4:0]    in_rt;
    logic [4:0]    in_rd;
    logic [15:0]   in_imm;
    logic [25:0]   in_target;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [AW-1:0] out_addr;
    logic          base_load;
    logic [AW-1:0] base_addr;
    logic          err;
    logic          clr_err;
    logic [15:0]   words_issued;

    modport master (
        output in_valid, in_opcode, in_aluop, in_rs, in_rt, in_rd, in_imm, in_target,
        output out_ready, base_load, base_addr, clr_err,
        input  in_ready, out_valid, out_data, out_addr, err, words_issued
    );

    modport slave (
        input  in_valid, in_opcode, in_aluop, in_rs, in_rt, in_rd, in_imm, in_target,
        input  out_ready, base_load, base_addr, clr_err,
        output in_ready, out_valid, out_data, out_addr, err, words_issued
    );
endinterface

// File: rtl/mips_instr_encoder.sv
// Packs symbolic MIPS fields into 32-bit words, buffers them in a FIFO and streams them
// out with a byte address. Define MIPS_DELAY_SLOT_NOP_EN to pad branches/jumps with a NOP.
module mips_instr_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input logic               clk,
    input logic               rst,
    mips_instr_encoder_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   words_q;
    logic          err_q;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic [5:0]  funct;
    logic        full, idle, accept, push_legal, pad_push, push, pop;
    logic [31:0] push_word;

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        funct     = '0;
        case (bus.in_opcode)
            OpRtype: begin
                case (bus.in_aluop)
                    4'd2:    funct = 6'b100000;
                    4'd6:    funct = 6'b100010;
                    4'd0:    funct = 6'b100100;
                    4'd1:    funct = 6'b100101;
                    4'd12:   funct = 6'b100111;
                    4'd7:    funct = 6'b101010;
                    4'd13:   funct = 6'b100110;
                    default: enc_legal = 1'b0;
                endcase
                enc_word = {OpRtype, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, funct};
            end
            OpLw, OpSw, OpAddi, OpBeq, OpBne:
                enc_word = {bus.in_opcode, bus.in_rs, bus.in_rt, bus.in_imm};
            OpJ:     enc_word = {OpJ, bus.in_target};
            default: enc_legal = 1'b0;
        endcase
    end

    assign full       = (count_q == FullCount);
    assign accept     = bus.in_valid & bus.in_ready;
    assign push_legal = accept & enc_legal;
    assign pop        = bus.out_valid & bus.out_ready;

`ifdef MIPS_DELAY_SLOT_NOP_EN
    typedef enum logic [0:0] {StIdle, StPad} state_e;
    state_e state_q;
    logic   enc_branch;

    assign enc_branch = (bus.in_opcode == OpBeq) || (bus.in_opcode == OpBne) ||
                        (bus.in_opcode == OpJ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle:  if (push_legal && enc_branch) state_q <= StPad;
                StPad:   if (!full) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign idle     = (state_q == StIdle);
    assign pad_push = (state_q == StPad) && !full;
`else
    assign idle     = 1'b1;
    assign pad_push = 1'b0;
`endif

    // in_ready depends only on registered state, never on in_valid.
    assign bus.in_ready = !full && idle;
    assign push         = push_legal | pad_push;
    assign push_word    = pad_push ? 32'h0000_0000 : enc_word;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // base_load overrides the post-handshake increment; the current word keeps the old address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else if (bus.base_load) begin
            addr_q <= bus.base_addr & ~AW'(3);
        end else if (pop) begin
            addr_q <= addr_q + AW'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_q <= '0;
        end else if (pop && (words_q != 16'hFFFF)) begin
            words_q <= words_q + 16'd1;
        end
    end

    // A new illegal accept beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept && !enc_legal) begin
            err_q <= 1'b1;
        end else if (bus.clr_err) begin
            err_q <= 1'b0;
        end
    end

    assign bus.out_valid    = (count_q != '0);
    assign bus.out_data     = bus.out_valid ? mem[rd_ptr_q] : 32'h0000_0000;
    assign bus.out_addr     = addr_q;
    assign bus.err          = err_q;
    assign bus.words_issued = words_q;
endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed-vector bench for mips_instr_encoder; honours MIPS_DELAY_SLOT_NOP_EN if defined.
module tb_mips_instr_encoder;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    mips_instr_encoder_if #(.AW(32)) bus ();

    mips_instr_encoder #(.DEPTH(4), .AW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge; returns 1 time unit after the accept edge.
    task automatic send(input logic [5:0] op, input logic [3:0] alu, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                        input logic [25:0] tgt);
        int n;
        n = 0;
        bus.in_opcode = op;
        bus.in_aluop  = alu;
        bus.in_rs     = rs;
        bus.in_rt     = rt;
        bus.in_rd     = rd;
        bus.in_imm    = imm;
        bus.in_target = tgt;
        bus.in_valid  = 1'b1;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("send_timeout", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic load_base(input logic [31:0] a);
        bus.base_load = 1'b1;
        bus.base_addr = a;
        step();
        bus.base_load = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_opcode = '0;
        bus.in_aluop  = '0;
        bus.in_rs     = '0;
        bus.in_rt     = '0;
        bus.in_rd     = '0;
        bus.in_imm    = '0;
        bus.in_target = '0;
        bus.out_ready = 1'b1;
        bus.base_load = 1'b0;
        bus.base_addr = '0;
        bus.clr_err   = 1'b0;
        step();
        step();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'h0);
        check("rst_out_addr", bus.out_addr, 32'h0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_words", 32'(bus.words_issued), 32'd0);
        rst = 1'b0;
        step();
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // ADD r10 = r8 + r9
        send(6'b000000, 4'd2, 5'd8, 5'd9, 5'd10, 16'h0, 26'h0);
        check("add_valid", 32'(bus.out_valid), 32'd1);
        check("add_data", bus.out_data, 32'h01095020);
        check("add_addr", bus.out_addr, 32'h0);
        step();
        check("add_words", 32'(bus.words_issued), 32'd1);
        check("add_drained", 32'(bus.out_valid), 32'd0);

        // LW / SW after base load
        load_base(32'h100);
        send(6'b100011, 4'd0, 5'd2, 5'd8, 5'd0, 16'd4, 26'h0);
        check("lw_data", bus.out_data, 32'h8C480004);
        check("lw_addr", bus.out_addr, 32'h100);
        step();
        send(6'b101011, 4'd0, 5'd2, 5'd9, 5'd0, 16'd8, 26'h0);
        check("sw_data", bus.out_data, 32'hAC490008);
        check("sw_addr", bus.out_addr, 32'h104);
        step();
        check("sw_words", 32'(bus.words_issued), 32'd3);

        // Fill FIFO with ADDI r1 = r0 + k, address wraps from 0xFFFFFFFC
        bus.out_ready = 1'b0;
        load_base(32'hFFFF_FFFF);
        check("base_lowbits", bus.out_addr, 32'hFFFF_FFFC);
        for (int k = 1; k <= 4; k++) send(6'b001000, 4'd0, 5'd0, 5'd1, 5'd0, 16'(k), 26'h0);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_opcode = 6'b001000;
        bus.in_rt     = 5'd1;
        bus.in_imm    = 16'd5;
        bus.in_valid  = 1'b1;
        step();
        check("full_hold_ready", 32'(bus.in_ready), 32'd0);
        check("full_w1_data", bus.out_data, 32'h20010001);
        check("full_w1_addr", bus.out_addr, 32'hFFFF_FFFC);
        bus.out_ready = 1'b1;
        step();
        check("drain_ready", 32'(bus.in_ready), 32'd1);
        check("drain_w2_data", bus.out_data, 32'h20010002);
        check("drain_w2_addr", bus.out_addr, 32'h0);
        step();
        bus.in_valid = 1'b0;
        check("drain_w3_data", bus.out_data, 32'h20010003);
        check("drain_w3_addr", bus.out_addr, 32'h4);
        step();
        check("drain_w4_data", bus.out_data, 32'h20010004);
        step();
        check("drain_w5_data", bus.out_data, 32'h20010005);
        check("drain_w5_addr", bus.out_addr, 32'hC);
        step();
        check("drain_empty", 32'(bus.out_valid), 32'd0);
        check("drain_words", 32'(bus.words_issued), 32'd8);

        // Illegal encodings and err handling
        send(6'b111111, 4'd0, 5'd1, 5'd2, 5'd0, 16'h1234, 26'h0);
        check("badop_err", 32'(bus.err), 32'd1);
        check("badop_novalid", 32'(bus.out_valid), 32'd0);
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        check("clr_err", 32'(bus.err), 32'd0);
        send(6'b000000, 4'd3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        check("badalu_err", 32'(bus.err), 32'd1);
        check("badalu_novalid", 32'(bus.out_valid), 32'd0);
        bus.clr_err = 1'b1;
        send(6'b000000, 4'd3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        bus.clr_err = 1'b0;
        check("set_beats_clr", 32'(bus.err), 32'd1);
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        send(6'b000000, 4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        check("or_data", bus.out_data, 32'h00221825);
        check("or_addr", bus.out_addr, 32'h10);
        check("or_err", 32'(bus.err), 32'd0);
        step();
        send(6'b000000, 4'd13, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
        check("xor_data", bus.out_data, 32'h00853026);
        step();
        check("legal_words", 32'(bus.words_issued), 32'd10);

        // BEQ r8, r9, 3
        send(6'b000100, 4'd0, 5'd8, 5'd9, 5'd0, 16'd3, 26'h0);
        check("beq_data", bus.out_data, 32'h11090003);
        check("beq_addr", bus.out_addr, 32'h18);
`ifdef MIPS_DELAY_SLOT_NOP_EN
        check("beq_pad_ready", 32'(bus.in_ready), 32'd0);
        step();
        check("nop_valid", 32'(bus.out_valid), 32'd1);
        check("nop_data", bus.out_data, 32'h0);
        check("nop_addr", bus.out_addr, 32'h1C);
        check("nop_ready", 32'(bus.in_ready), 32'd1);
        step();
        check("nop_words", 32'(bus.words_issued), 32'd12);
`else
        check("beq_ready", 32'(bus.in_ready), 32'd1);
        step();
        check("beq_no_nop", 32'(bus.out_valid), 32'd0);
        check("beq_words", 32'(bus.words_issued), 32'd11);
`endif

        // Asynchronous reset with a partly full FIFO
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) send(6'b001000, 4'd0, 5'd0, 5'd1, 5'd0, 16'(k), 26'h0);
        send(6'b111111, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        check("pre_rst_err", 32'(bus.err), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_addr", bus.out_addr, 32'h0);
        check("arst_words", 32'(bus.words_issued), 32'd0);
        check("arst_err", 32'(bus.err), 32'd0);
        check("arst_data", bus.out_data, 32'h0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_ready", 32'(bus.in_ready), 32'd1);
        check("post_rst_valid", 32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
